ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_host_tx.sv | 156 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 host transmit shared types and elaboration helpers.
// Cycle counts are derived from microsecond parameters at elaboration.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        BITS,
        ACK,
        DONE,
        ERR
    } ps2_tx_state_t;

    // stop, parity, d7..d0
    localparam int FRAME_LEN = 10;
    localparam int BIT_W     = $clog2(FRAME_LEN);

    function automatic int us_to_cycles(input longint us, input longint hz);
        return int'((us * hz) / 1000000);
    endfunction

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int CNT_W = cnt_width(us_to_cycles(15000, 50000000));

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one PS/2 pad.
// The level follows the pad only after FILTER_LEN agreeing samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pad_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          s1_q;
    logic          s2_q;
    logic          lvl_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            lvl_q  <= 1'b1;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= pad_i;
            s2_q   <= s1_q;
            fall_q <= 1'b0;
            if (s2_q == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                lvl_q  <= s2_q;
                fall_q <= ~s2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = lvl_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Drives the open-drain pads only through registered pull-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 50000000,
    parameter int INHIBIT_US      = 120,
    parameter int FIRST_EDGE_US   = 15000,
    parameter int EDGE_TIMEOUT_US = 2000,
    parameter int FILTER_LEN      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_C   = us_to_cycles(INHIBIT_US, CLK_FREQ_HZ);
    localparam int FIRST_C = us_to_cycles(FIRST_EDGE_US, CLK_FREQ_HZ);
    localparam int EDGE_C  = us_to_cycles(EDGE_TIMEOUT_US, CLK_FREQ_HZ);
    localparam int MAX_A   = (FIRST_C > EDGE_C) ? FIRST_C : EDGE_C;
    localparam int MAX_C   = (MAX_A > INH_C) ? MAX_A : INH_C;
    localparam int CW      = cnt_width(MAX_C);

    ps2_tx_state_t        state_q;
    logic [CW-1:0]        cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [FRAME_LEN-1:0] word_q;
    logic                 rdy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 busy_q;
    logic                 clk_oe_q;
    logic                 data_oe_q;

    logic clk_lvl_unused;
    logic clk_fall;
    logic data_lvl;
    logic data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .pad_i   (ps2_clk_i),
        .level_o (clk_lvl_unused),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .pad_i   (ps2_data_i),
        .level_o (data_lvl),
        .fall_o  (data_fall_unused)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            word_q    <= '0;
            rdy_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (tx_valid && rdy_q) begin
                        word_q   <= {1'b1, ~^tx_data, tx_data};
                        // two cycles are spent entering INHIBIT and RELEASE
                        cnt_q    <= CW'(INH_C - 2);
                        clk_oe_q <= 1'b1;
                        rdy_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt_q == '0) begin
                        data_oe_q <= 1'b1;
                        state_q   <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RELEASE: begin
                    clk_oe_q <= 1'b0;
                    cnt_q    <= CW'(FIRST_C);
                    bit_q    <= '0;
                    state_q  <= BITS;
                end
                BITS: begin
                    if (clk_fall) begin
                        data_oe_q <= ~word_q[bit_q];
                        bit_q     <= bit_q + 1'b1;
                        cnt_q     <= CW'(EDGE_C);
                        if (bit_q == BIT_W'(FRAME_LEN - 1)) begin
                            state_q <= ACK;
                        end
                    end else if (cnt_q == '0) begin
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        state_q <= data_lvl ? ERR : DONE;
                    end else if (cnt_q == '0) begin
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                ERR: begin
                    err_q     <= 1'b1;
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    rdy_q     <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready    = rdy_q;
    assign tx_done     = done_q;
    assign tx_error    = err_q;
    assign busy        = busy_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: vector table, random bytes against a frame model,
// and hand-written timeout, glitch, busy and reset sequences.
module tb_ps2_host_tx;

    localparam int CLK_HZ   = 2000000;
    localparam int INH_US   = 60;
    localparam int FIRST_US = 1500;
    localparam int EDGE_US  = 200;
    localparam int FLEN     = 8;
    localparam int INH_C    = INH_US * (CLK_HZ / 1000000);
    localparam int FIRST_C  = FIRST_US * (CLK_HZ / 1000000);
    localparam int EDGE_C   = EDGE_US * (CLK_HZ / 1000000);
    localparam int H        = 30;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;
    wire        clk_line  = !(ps2_clk_oe || dev_clk_low);
    wire        data_line = !(ps2_data_oe || dev_data_low);

    always #10 clk = ~clk;

    ps2_host_tx #(
        .CLK_FREQ_HZ     (CLK_HZ),
        .INHIBIT_US      (INH_US),
        .FIRST_EDGE_US   (FIRST_US),
        .EDGE_TIMEOUT_US (EDGE_US),
        .FILTER_LEN      (FLEN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .busy        (busy),
        .ps2_clk_i   (clk_line),
        .ps2_data_i  (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int cyc = 0;
    int ndone = 0, nerr = 0, nboth = 0, err_cyc = 0;
    int n_pass = 0, n_total = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tx_done) ndone++;
        if (tx_error) begin
            nerr++;
            err_cyc = cyc;
        end
        if (tx_done && tx_error) nboth++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk_rng(input string nm, input longint act,
                           input longint lo, input longint hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endtask

    // Frame the device should see: data LSB first, odd parity, stop high.
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    task automatic xfer(input logic [7:0] d, input int nclk, input bit ack_low,
                        input bit extra, output logic [9:0] got,
                        output int inh_len, output bit start_ok,
                        output int rel_cyc, output int fall4_cyc,
                        output bit finished);
        int n;
        int base;
        bit last;
        got = '0;
        fall4_cyc = 0;
        base = ndone + nerr;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (extra) tx_data = ~d;
        else tx_valid = 1'b0;
        n = 0;
        last = 1'b0;
        while (ps2_clk_oe && n < 10000) begin
            last = ps2_data_oe;
            n++;
            @(negedge clk);
        end
        inh_len  = n;
        start_ok = last && ps2_data_oe;
        rel_cyc  = cyc;
        tx_valid = 1'b0;
        for (int i = 0; i < nclk; i++) begin
            if (i == 10) dev_data_low = ack_low;
            repeat (H) @(negedge clk);
            if (extra && i == 3) begin
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (H) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            if (i == 3) fall4_cyc = cyc;
            repeat (H) @(negedge clk);
            if (i < 10) got[i] = data_line;
            dev_clk_low = 1'b0;
        end
        repeat (H) @(negedge clk);
        dev_data_low = 1'b0;
        n = 0;
        while ((ndone + nerr) == base && n < FIRST_C + EDGE_C + 500) begin
            @(negedge clk);
            n++;
        end
        finished = ((ndone + nerr) != base);
    endtask

    task automatic run_vec(input string tag, input logic [7:0] d,
                           input bit ack_low, input bit extra,
                           input logic [9:0] exp_bits, input bit exp_done);
        logic [9:0] got;
        int inh, rel, f4, bd, be;
        bit sok, fin;
        bd = ndone;
        be = nerr;
        xfer(d, 11, ack_low, extra, got, inh, sok, rel, f4, fin);
        repeat (4) @(negedge clk);
        chk($sformatf("%s bits", tag), got, exp_bits);
        chk_rng($sformatf("%s inhibit len", tag), inh, INH_C - 1, INH_C + 1);
        chk($sformatf("%s start bit", tag), sok, 1);
        chk($sformatf("%s finished", tag), fin, 1);
        chk($sformatf("%s done count", tag), ndone - bd, exp_done ? 1 : 0);
        chk($sformatf("%s error count", tag), nerr - be, exp_done ? 0 : 1);
        chk($sformatf("%s ready", tag), tx_ready, 1);
        chk($sformatf("%s busy", tag), busy, 0);
        chk($sformatf("%s oe", tag), {ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    typedef struct {
        logic [7:0] d;
        bit         ack_low;
        logic [9:0] exp_bits;
        bit         exp_done;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [9:0] got;
        logic [7:0] rd;
        int inh, rel, f4, bd, be, n;
        bit sok, fin, ra;

        vecs[0] = '{8'hED, 1'b1, 10'b11_1110_1101, 1'b1};
        vecs[1] = '{8'hF4, 1'b1, 10'b10_1111_0100, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 10'b11_1111_1111, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 10'b11_0000_0000, 1'b0};

        reset_n = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ready", tx_ready, 0);
        chk("reset busy", busy, 0);
        chk("reset oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("reset pulses", {tx_done, tx_error}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", tx_ready, 1);

        for (int i = 0; i < 4; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].d, vecs[i].ack_low, 1'b0,
                    vecs[i].exp_bits, vecs[i].exp_done);

        for (int i = 0; i < 5; i++) begin
            rd = 8'($urandom_range(0, 255));
            ra = ($urandom_range(0, 3) != 0);
            run_vec($sformatf("rand%0d", i), rd, ra, 1'b0, ref_frame(rd), ra);
        end

        bd = ndone;
        be = nerr;
        xfer(8'hFF, 0, 1'b1, 1'b0, got, inh, sok, rel, f4, fin);
        repeat (3) @(negedge clk);
        chk("noclk finished", fin, 1);
        chk_rng("noclk timeout", err_cyc - rel, FIRST_C - 1, FIRST_C + 3);
        chk("noclk error count", nerr - be, 1);
        chk("noclk done count", ndone - bd, 0);
        chk("noclk oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("noclk ready", tx_ready, 1);

        bd = ndone;
        be = nerr;
        xfer(8'hA5, 4, 1'b1, 1'b0, got, inh, sok, rel, f4, fin);
        repeat (3) @(negedge clk);
        chk("stall finished", fin, 1);
        chk_rng("stall timeout", err_cyc - f4, EDGE_C + FLEN + 3, EDGE_C + FLEN + 7);
        chk("stall error count", nerr - be, 1);
        chk("stall done count", ndone - bd, 0);
        chk("stall oe", {ps2_clk_oe, ps2_data_oe}, 0);

        run_vec("glitch+busy", 8'h3C, 1'b1, 1'b1, ref_frame(8'h3C), 1'b1);

        @(negedge clk);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (ps2_clk_oe && n < 1000) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 2; i++) begin
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        chk("mid data_oe", ps2_data_oe, 1);
        chk("mid busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("async reset oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("async reset ready", tx_ready, 0);
        chk("async reset busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post reset ready", tx_ready, 1);
        chk("post reset busy", busy, 0);

        chk("done and error together", nboth, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
